dpram_frame_reader: RTL and testbench

- Streaming read master for port B of the 8192x32 dual-port frame-buffer RAM.
- Fetches a programmed window of words in sequence and buffers them in a small FIFO, so the RAM's 1-cycle synchronous read latency and any downstream back-pressure are absorbed.
- Presents the words as a valid/ready pixel-word stream with start-of-frame and end-of-frame tags, for the LCD timing/serialiser logic.
- Port A stays with the CPU bus; this block never writes the RAM.

---
 rtl/dpram_frame_reader_pkg.sv | 18 +
 rtl/dpram_frame_reader_fifo.sv | 41 ++++
 rtl/dpram_frame_reader.sv | 131 +++++++++++++
 tb/tb_dpram_frame_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_frame_reader_pkg.sv
// dpram_frame_reader_pkg: shared types and constants for the port-B frame reader.
package dpram_frame_reader_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    localparam int RAM_WORDS = 8192;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [31:0] data;
    } fifo_entry_t;

    function automatic logic [31:0] swap_bytes(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/dpram_frame_reader_fifo.sv
// dpram_frame_reader_fifo: synchronous FIFO with occupancy count; head reads as zero when empty.
module dpram_frame_reader_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/dpram_frame_reader.sv
// dpram_frame_reader: streams a window of frame-buffer words from RAM port B as a tagged valid/ready stream.
// Optional byte swap of each word under DPRAM_FRAME_READER_BYTE_SWAP_EN (adds the SWAP input).
module dpram_frame_reader
    import dpram_frame_reader_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              START,
    input  logic              STOP,
    input  logic              CONTINUOUS,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W:0]   FRAME_WORDS,
`ifdef DPRAM_FRAME_READER_BYTE_SWAP_EN
    input  logic              SWAP,
`endif
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              CEB,
    output logic [ADDR_W-1:0] ADDRB,
    output logic [3:0]        WEB,
    output logic [31:0]       DIB,
    input  logic [31:0]       DOB,
    output logic [31:0]       PIX_DATA,
    output logic              PIX_VALID,
    input  logic              PIX_READY,
    output logic              PIX_SOF,
    output logic              PIX_EOF
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, idx_q;
    logic [ADDR_W:0]   words_q;
    logic              cont_q, stop_q, inflight_q, sof_q, eof_q, done_q;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty, issue, last, start_ok, pop, repeat_frame;
    logic [31:0]       push_data;
    fifo_entry_t       push_entry, head;

    assign start_ok     = START && FRAME_WORDS != '0;
    // credit counts the read still in flight so the FIFO can never overflow
    assign issue        = state_q == FETCH && int'(fifo_count) + int'(inflight_q) < FIFO_DEPTH;
    assign last         = {1'b0, idx_q} == words_q - (ADDR_W+1)'(1);
    assign repeat_frame = cont_q && !stop_q && !STOP;
    assign pop          = !fifo_empty && PIX_READY;

`ifdef DPRAM_FRAME_READER_BYTE_SWAP_EN
    logic swap_q;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) swap_q <= 1'b0;
        else if (state_q == IDLE && start_ok) swap_q <= SWAP;
    end
    assign push_data = swap_q ? swap_bytes(DOB) : DOB;
`else
    assign push_data = DOB;
`endif

    assign push_entry = '{sof: sof_q, eof: eof_q, data: push_data};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start_ok ? FETCH : IDLE;
            FETCH:   state_d = (issue && last && !repeat_frame) ? DRAIN : FETCH;
            DRAIN:   state_d = (fifo_empty && !inflight_q) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY       = state_q != IDLE;
        CEB        = issue;
        ADDRB      = issue ? base_q + idx_q : '0;
        WEB        = 4'b0000;
        DIB        = '0;
        FRAME_DONE = done_q;
        PIX_VALID  = !fifo_empty;
        PIX_DATA   = head.data;
        PIX_SOF    = head.sof;
        PIX_EOF    = head.eof;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            base_q     <= '0;
            idx_q      <= '0;
            words_q    <= '0;
            cont_q     <= 1'b0;
            stop_q     <= 1'b0;
            inflight_q <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            sof_q      <= issue && idx_q == '0;
            eof_q      <= issue && last;
            done_q     <= pop && head.eof;
            if (state_q == IDLE && start_ok) begin
                base_q  <= BASE_ADDR;
                words_q <= FRAME_WORDS;
                cont_q  <= CONTINUOUS;
                stop_q  <= 1'b0;
                idx_q   <= '0;
            end else begin
                if (STOP && state_q != IDLE) stop_q <= 1'b1;
                if (issue) idx_q <= last ? '0 : idx_q + ADDR_W'(1);
            end
        end
    end

    dpram_frame_reader_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fifo_entry_t))) u_fifo (
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .push_i (inflight_q),
        .data_i (push_entry),
        .pop_i  (pop),
        .data_o (head),
        .count_o(fifo_count),
        .empty_o(fifo_empty)
    );

endmodule

// File: tb/tb_dpram_frame_reader.sv
// tb_dpram_frame_reader: randomized scoreboard bench with a RAM model and a frame-level reference.
module tb_dpram_frame_reader;
    logic        HCLK = 1'b0, HRESETn = 1'b0, START = 1'b0, STOP = 1'b0, CONTINUOUS = 1'b0;
    logic [12:0] BASE_ADDR = '0;
    logic [13:0] FRAME_WORDS = '0;
    logic        BUSY, FRAME_DONE, CEB, PIX_VALID, PIX_SOF, PIX_EOF;
    logic        PIX_READY = 1'b1;
    logic [12:0] ADDRB;
    logic [3:0]  WEB;
    logic [31:0] DIB, DOB, PIX_DATA;
    logic        swap = 1'b0;

    dpram_frame_reader dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .START(START), .STOP(STOP), .CONTINUOUS(CONTINUOUS),
        .BASE_ADDR(BASE_ADDR), .FRAME_WORDS(FRAME_WORDS),
`ifdef DPRAM_FRAME_READER_BYTE_SWAP_EN
        .SWAP(swap),
`endif
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .CEB(CEB), .ADDRB(ADDRB), .WEB(WEB), .DIB(DIB),
        .DOB(DOB), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .PIX_SOF(PIX_SOF), .PIX_EOF(PIX_EOF)
    );

    always #5 HCLK = ~HCLK;

    logic [31:0] ram [8192];
    always @(posedge HCLK) if (CEB) DOB <= ram[ADDRB];

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic        e;
    } exp_t;
    exp_t        exp_q[$];
    logic [12:0] addr_q[$];
    int checks = 0, errors = 0;
    int done_cnt = 0, ceb_cnt = 0, occ = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // reference: a frame is n consecutive words from base, wrapping the 8K address space
    task automatic expect_frame(input int base, input int n, input bit sw);
        for (int k = 0; k < n; k++) begin
            logic [12:0] a;
            exp_t e;
            a = 13'((base + k) % 8192);
            addr_q.push_back(a);
            e.d = sw ? bswap(ram[a]) : ram[a];
            e.s = k == 0;
            e.e = k == n - 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input int base, input int n, input bit cont, input bit sw);
        @(negedge HCLK);
        BASE_ADDR = 13'(base);
        FRAME_WORDS = 14'(n);
        CONTINUOUS = cont;
        swap = sw;
        START = 1'b1;
        @(negedge HCLK);
        START = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (BUSY && t < 3000) begin
            @(negedge HCLK);
            t++;
        end
        chk({name, "_busy_timeout"}, 32'(BUSY), 0);
        @(negedge HCLK);
        chk({name, "_left_over"}, exp_q.size(), 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, {BUSY, FRAME_DONE, CEB, PIX_VALID, PIX_SOF, PIX_EOF}, 0);
        chk({name, "_addrb"}, 32'(ADDRB), 0);
        chk({name, "_data"}, PIX_DATA, 0);
        chk({name, "_tied"}, {WEB, DIB[27:0]} | 32'(DIB[31:28]), 0);
    endtask

    // monitor: sampled #1 after the falling edge, where inputs for the next rising edge are settled
    logic        hold_v = 1'b0, hold_s, hold_e, pend = 1'b0;
    logic [31:0] hold_d;
    always begin
        @(negedge HCLK);
        #1;
        if (!HRESETn) begin
            occ = 0;
            hold_v = 1'b0;
            pend = 1'b0;
        end else begin
            if (pend || FRAME_DONE) chk("frame_done", 32'(FRAME_DONE), 32'(pend));
            if (FRAME_DONE) done_cnt++;
            if (hold_v) begin
                chk("hold_valid", 32'(PIX_VALID), 1);
                chk("hold_data", PIX_DATA, hold_d);
                chk("hold_tags", {PIX_SOF, PIX_EOF}, {hold_s, hold_e});
            end
            if (CEB) begin
                ceb_cnt++;
                chk("credit", 32'(occ < 8), 1);
                if (addr_q.size() == 0) chk("unexpected_read", 32'(ADDRB), 32'hFFFF_FFFF);
                else chk("addrb", 32'(ADDRB), 32'(addr_q.pop_front()));
                occ++;
            end
            pend = 1'b0;
            if (PIX_VALID && PIX_READY) begin
                if (exp_q.size() == 0) chk("unexpected_word", PIX_DATA, 32'hDEAD_BEEF);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pix_data", PIX_DATA, e.d);
                    chk("pix_tags", {PIX_SOF, PIX_EOF}, {e.s, e.e});
                end
                pend = PIX_EOF;
                occ--;
            end
            hold_v = PIX_VALID && !PIX_READY;
            hold_d = PIX_DATA;
            hold_s = PIX_SOF;
            hold_e = PIX_EOF;
        end
    end

    initial begin
        int d0, c0, base, n;
        for (int i = 0; i < 8192; i++) ram[i] = i;
        repeat (3) @(negedge HCLK);
        chk_zero("reset");
        HRESETn = 1'b1;

        // single frame, ready held high: latency and tags
        d0 = done_cnt;
        c0 = ceb_cnt;
        expect_frame(16, 4, 0);
        do_start(16, 4, 0, 0);
        chk("lat_c1", 32'(PIX_VALID), 0);
        @(negedge HCLK);
        chk("lat_c2", 32'(PIX_VALID), 0);
        @(negedge HCLK);
        chk("lat_c3", 32'(PIX_VALID), 1);
        wait_idle("t1");
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_reads", ceb_cnt - c0, 4);

        for (int i = 0; i < 8192; i++) ram[i] = $urandom;

        // address wrap
        expect_frame(13'h1FFE, 4, 0);
        do_start(13'h1FFE, 4, 0, 0);
        wait_idle("wrap");

        // back-pressure: one frame with a 20-cycle stall, then random frames
        for (int f = 0; f < 4; f++) begin
            base = $urandom_range(0, 8191);
            n = f == 0 ? 32 : $urandom_range(1, 40);
            d0 = done_cnt;
            expect_frame(base, n, 0);
            do_start(base, n, 0, 0);
            for (int c = 0; c < 150; c++) begin
                PIX_READY = (f == 0 && c >= 4 && c < 24) ? 1'b0 : 1'($urandom);
                @(negedge HCLK);
            end
            PIX_READY = 1'b1;
            wait_idle("bp");
            chk("bp_done", done_cnt - d0, 1);
        end

        // continuous frames of 3, stop during frame 2
        d0 = done_cnt;
        c0 = ceb_cnt;
        expect_frame(100, 3, 0);
        expect_frame(100, 3, 0);
        do_start(100, 3, 1, 0);
        repeat (3) @(negedge HCLK);
        STOP = 1'b1;
        @(negedge HCLK);
        STOP = 1'b0;
        repeat (2) @(negedge HCLK);
        #2;
        chk("cont_no_bubble", ceb_cnt - c0, 6);
        wait_idle("cont");
        chk("cont_done", done_cnt - d0, 2);
        chk("cont_reads", ceb_cnt - c0, 6);

        // START while busy and START with zero words are ignored
        c0 = ceb_cnt;
        expect_frame(500, 20, 0);
        do_start(500, 20, 0, 0);
        @(negedge HCLK);
        do_start(7000, 5, 1, 0);
        wait_idle("busy_start");
        chk("busy_start_reads", ceb_cnt - c0, 20);
        c0 = ceb_cnt;
        do_start(600, 0, 0, 0);
        repeat (6) @(negedge HCLK);
        chk("zero_busy", 32'(BUSY), 0);
        chk("zero_reads", ceb_cnt - c0, 0);

        // asynchronous reset mid-frame, then a fresh frame
        PIX_READY = 1'b0;
        expect_frame(42, 30, 0);
        do_start(42, 30, 0, 0);
        repeat (5) @(negedge HCLK);
        HRESETn = 1'b0;
        exp_q.delete();
        addr_q.delete();
        #1;
        chk_zero("mid_reset");
        PIX_READY = 1'b1;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        d0 = done_cnt;
        expect_frame(8000, 9, 0);
        do_start(8000, 9, 0, 0);
        wait_idle("after_reset");
        chk("after_reset_done", done_cnt - d0, 1);

`ifdef DPRAM_FRAME_READER_BYTE_SWAP_EN
        ram[256] = 32'h11223344;
        expect_frame(256, 1, 1);
        chk("swap_model", exp_q[0].d, 32'h44332211);
        do_start(256, 1, 0, 1);
        wait_idle("swap");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
